oflow_similarity_score_engine: RTL and testbench

OFLOW_SIMILARITY_SCORE_ENGINE -- requirements
Module: oflow_similarity_score_engine

---
 rtl/oflow_similarity_score_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_oflow_similarity_score_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_similarity_score_engine.sv
// rtl/oflow_similarity_score_engine.sv - 3-stage weighted similarity scorer with per-group minimum tracker
module oflow_similarity_score_engine #(
    parameter int NUM_COLOR  = 2,
    parameter int DIM_BITS   = 8,
    parameter int HIST_BITS  = 4,
    parameter int WEIGHT_LEN = 8,
    parameter int FRAC       = 10,
    parameter int SCORE_LEN  = 32,
    parameter int ID_LEN     = 12
) (
    input  logic                                  clk,
    input  logic                                  reset_N,
    input  logic                                  cfg_load,
    input  logic [(4+NUM_COLOR)*WEIGHT_LEN-1:0]   cfg_weights,
    output logic                                  cfg_err,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic [ID_LEN-1:0]                     in_id,
    input  logic [FRAC-1:0]                       iou_dist,
    input  logic [DIM_BITS-1:0]                   w_cur,
    input  logic [DIM_BITS-1:0]                   w_prev,
    input  logic [DIM_BITS-1:0]                   h_cur,
    input  logic [DIM_BITS-1:0]                   h_prev,
    input  logic [NUM_COLOR*24-1:0]               color_cur,
    input  logic [NUM_COLOR*24-1:0]               color_prev,
    input  logic [HIST_BITS-1:0]                  d_history,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SCORE_LEN-1:0]                  out_score,
    output logic [ID_LEN-1:0]                     out_id,
    output logic                                  out_last,
    output logic                                  best_valid,
    output logic [SCORE_LEN-1:0]                  best_score,
    output logic [ID_LEN-1:0]                     best_id,
    output logic [ID_LEN-1:0]                     best_count,
    output logic                                  busy
);
    // Term layout matches the weight packing: colors at 0..NUM_COLOR-1, then iou, w, h, hist.
    localparam int NT       = 4 + NUM_COLOR;
    localparam int IDX_IOU  = NUM_COLOR;
    localparam int IDX_W    = NUM_COLOR + 1;
    localparam int IDX_H    = NUM_COLOR + 2;
    localparam int IDX_HIST = NUM_COLOR + 3;
    localparam int CD_W     = 10;
    localparam int HIST_W   = 1 << HIST_BITS;
    localparam int T1       = (DIM_BITS > CD_W) ? DIM_BITS : CD_W;
    localparam int T2       = (T1 > HIST_W) ? T1 : HIST_W;
    localparam int PROD_W   = T2 + FRAC + WEIGHT_LEN;
    localparam int SUM_A    = PROD_W + $clog2(NT) + 1;
    localparam int SUM_W    = (SUM_A > SCORE_LEN) ? SUM_A : SCORE_LEN + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_t;

    logic                         stall;
    logic                         beat;
    logic [NT*WEIGHT_LEN-1:0]     weights_q;
    logic                         cfg_err_q;

    logic [DIM_BITS-1:0]          s1_w_d, s1_h_d;
    logic [CD_W-1:0]              s1_c_d [NUM_COLOR];
    logic [HIST_W-1:0]            s1_hist_d;
    logic [7:0]                   ch_a, ch_b;

    logic                         s1_valid_q, s1_last_q;
    logic [ID_LEN-1:0]            s1_id_q;
    logic [DIM_BITS-1:0]          s1_w_q, s1_h_q;
    logic [CD_W-1:0]              s1_c_q [NUM_COLOR];
    logic [HIST_W-1:0]            s1_hist_q;
    logic [FRAC-1:0]              s1_iou_q;

    logic [PROD_W-1:0]            term [NT];
    logic [PROD_W-1:0]            s2_prod_d [NT];
    logic                         s2_valid_q, s2_last_q;
    logic [ID_LEN-1:0]            s2_id_q;
    logic [PROD_W-1:0]            s2_prod_q [NT];

    logic [SUM_W-1:0]             sum_d;
    logic [SCORE_LEN-1:0]         score_d;
    logic                         out_valid_q, out_last_q;
    logic [SCORE_LEN-1:0]         out_score_q;
    logic [ID_LEN-1:0]            out_id_q;

    state_t                       state_q, state_d;
    logic [SCORE_LEN-1:0]         best_score_q, best_score_d;
    logic [ID_LEN-1:0]            best_id_q, best_id_d;
    logic [ID_LEN-1:0]            best_count_q, best_count_d;

    assign stall      = out_valid_q & ~out_ready;
    assign in_ready   = reset_N | ~stall;
    assign beat       = out_valid_q & out_ready;
    assign busy       = ~reset_N & (s1_valid_q | s2_valid_q | out_valid_q | (state_q != ST_IDLE));
    assign cfg_err    = cfg_err_q;
    assign out_valid  = out_valid_q;
    assign out_score  = out_score_q;
    assign out_id     = out_id_q;
    assign out_last   = out_last_q;
    assign best_valid = (state_q == ST_DONE);
    assign best_score = best_score_q;
    assign best_id    = best_id_q;
    assign best_count = best_count_q;

    // Weight register only changes while the datapath and tracker are empty.
    always_ff @(posedge clk) begin
        if (reset_N) begin
            weights_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_load & busy;
            if (cfg_load && !busy) begin
                weights_q <= cfg_weights;
            end
        end
    end

    // Stage 1 difference terms: absolute dimension deltas, per-feature color SAD, one-hot history.
    always_comb begin
        ch_a      = '0;
        ch_b      = '0;
        s1_w_d    = (w_prev >= w_cur) ? (w_prev - w_cur) : (w_cur - w_prev);
        s1_h_d    = (h_prev >= h_cur) ? (h_prev - h_cur) : (h_cur - h_prev);
        s1_hist_d = {{(HIST_W-1){1'b0}}, 1'b1} << d_history;
        for (int k = 0; k < NUM_COLOR; k++) begin
            s1_c_d[k] = '0;
            for (int ch = 0; ch < 3; ch++) begin
                ch_a      = color_cur[k*24 + ch*8 +: 8];
                ch_b      = color_prev[k*24 + ch*8 +: 8];
                s1_c_d[k] = s1_c_d[k] + CD_W'((ch_a >= ch_b) ? (ch_a - ch_b) : (ch_b - ch_a));
            end
        end
    end

    // Stage 2 products: integer terms scaled to q.FRAC, iou already fractional.
    always_comb begin
        for (int k = 0; k < NUM_COLOR; k++) begin
            term[k] = PROD_W'({s1_c_q[k], {FRAC{1'b0}}});
        end
        term[IDX_IOU]  = PROD_W'(s1_iou_q);
        term[IDX_W]    = PROD_W'({s1_w_q, {FRAC{1'b0}}});
        term[IDX_H]    = PROD_W'({s1_h_q, {FRAC{1'b0}}});
        term[IDX_HIST] = PROD_W'({s1_hist_q, {FRAC{1'b0}}});
        for (int i = 0; i < NT; i++) begin
            s2_prod_d[i] = term[i] * PROD_W'(weights_q[i*WEIGHT_LEN +: WEIGHT_LEN]);
        end
    end

    // Stage 3 sum with clamp to the largest representable score.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NT; i++) begin
            sum_d = sum_d + SUM_W'(s2_prod_q[i]);
        end
        score_d = (|sum_d[SUM_W-1:SCORE_LEN]) ? {SCORE_LEN{1'b1}} : sum_d[SCORE_LEN-1:0];
    end

    // Pipeline registers advance together and freeze as a whole while the output is stalled.
    always_ff @(posedge clk) begin
        if (reset_N) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_id_q     <= '0;
            s1_w_q      <= '0;
            s1_h_q      <= '0;
            s1_hist_q   <= '0;
            s1_iou_q    <= '0;
            for (int k = 0; k < NUM_COLOR; k++) s1_c_q[k] <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_id_q     <= '0;
            for (int i = 0; i < NT; i++) s2_prod_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
            out_score_q <= '0;
        end else if (!stall) begin
            s1_valid_q  <= in_valid;
            s1_last_q   <= in_last;
            s1_id_q     <= in_id;
            s1_w_q      <= s1_w_d;
            s1_h_q      <= s1_h_d;
            s1_hist_q   <= s1_hist_d;
            s1_iou_q    <= iou_dist;
            for (int k = 0; k < NUM_COLOR; k++) s1_c_q[k] <= s1_c_d[k];
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            s2_id_q     <= s1_id_q;
            for (int i = 0; i < NT; i++) s2_prod_q[i] <= s2_prod_d[i];
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_last_q;
            out_id_q    <= s2_id_q;
            out_score_q <= score_d;
        end
    end

    // Tracker state and best-so-far registers.
    always_ff @(posedge clk) begin
        if (reset_N) begin
            state_q      <= ST_IDLE;
            best_score_q <= '0;
            best_id_q    <= '0;
            best_count_q <= '0;
        end else begin
            state_q      <= state_d;
            best_score_q <= best_score_d;
            best_id_q    <= best_id_d;
            best_count_q <= best_count_d;
        end
    end

    // Tracker next state: DONE treats a beat like IDLE so consecutive groups are not split.
    always_comb begin
        state_d      = state_q;
        best_score_d = best_score_q;
        best_id_d    = best_id_q;
        best_count_d = best_count_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (beat) begin
                    best_score_d = out_score_q;
                    best_id_d    = out_id_q;
                    best_count_d = {{(ID_LEN-1){1'b0}}, 1'b1};
                    state_d      = out_last_q ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    if (out_score_q < best_score_q) begin
                        best_score_d = out_score_q;
                        best_id_d    = out_id_q;
                    end
                    if (best_count_q != {ID_LEN{1'b1}}) begin
                        best_count_d = best_count_q + 1'b1;
                    end
                    state_d = out_last_q ? ST_DONE : ST_ACCUM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_oflow_similarity_score_engine.sv
// tb/tb_oflow_similarity_score_engine.sv - directed vector bench for oflow_similarity_score_engine
module tb_oflow_similarity_score_engine;
    localparam logic [47:0] W_ONES = 48'h01_01_01_01_01_01;
    localparam logic [47:0] W_TWOS = 48'h02_02_02_02_02_02;
    localparam logic [47:0] W_IOU  = 48'h00_00_00_01_00_00;

    typedef struct {
        logic [7:0]  w_cur, w_prev, h_cur, h_prev;
        logic [47:0] c_cur, c_prev;
        logic [3:0]  dh;
        logic [9:0]  iou;
    } feat_t;

    typedef struct {
        logic [47:0] wts;
        feat_t       f;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic [11:0] id;
        logic [11:0] cnt;
    } rec_t;

    logic        clk, reset_N, cfg_load, cfg_err;
    logic [47:0] cfg_weights;
    logic        in_valid, in_ready, in_last;
    logic [11:0] in_id;
    logic [9:0]  iou_dist;
    logic [7:0]  w_cur, w_prev, h_cur, h_prev;
    logic [47:0] color_cur, color_prev;
    logic [3:0]  d_history;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_score, best_score;
    logic [11:0] out_id, best_id, best_count;
    logic        best_valid, busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vt [6];
    rec_t outq [$];
    rec_t bestq [$];

    oflow_similarity_score_engine dut (
        .clk(clk), .reset_N(reset_N), .cfg_load(cfg_load), .cfg_weights(cfg_weights),
        .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_id(in_id), .iou_dist(iou_dist), .w_cur(w_cur), .w_prev(w_prev),
        .h_cur(h_cur), .h_prev(h_prev), .color_cur(color_cur), .color_prev(color_prev),
        .d_history(d_history), .out_valid(out_valid), .out_ready(out_ready),
        .out_score(out_score), .out_id(out_id), .out_last(out_last),
        .best_valid(best_valid), .best_score(best_score), .best_id(best_id),
        .best_count(best_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset_N && out_valid && out_ready) outq.push_back('{out_score, out_id, 12'd0});
        if (best_valid) bestq.push_back('{best_score, best_id, best_count});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic feat_t mk(input logic [7:0] wc, input logic [7:0] wp, input logic [7:0] hc,
                                 input logic [7:0] hp, input logic [47:0] cc, input logic [47:0] cp,
                                 input logic [3:0] dh, input logic [9:0] iou);
        feat_t f;
        f.w_cur = wc; f.w_prev = wp; f.h_cur = hc; f.h_prev = hp;
        f.c_cur = cc; f.c_prev = cp; f.dh = dh; f.iou = iou;
        return f;
    endfunction

    task automatic load_weights(input logic [47:0] w);
        cfg_load = 1'b1;
        cfg_weights = w;
        tick();
        cfg_load = 1'b0;
        chk("cfg_err_idle_load", 64'(cfg_err), 64'(0));
    endtask

    task automatic send(input feat_t f, input logic [11:0] id, input logic last);
        int   n;
        logic hs;
        in_valid = 1'b1; in_id = id; in_last = last;
        w_cur = f.w_cur; w_prev = f.w_prev; h_cur = f.h_cur; h_prev = f.h_prev;
        color_cur = f.c_cur; color_prev = f.c_prev; d_history = f.dh; iou_dist = f.iou;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            n++;
        end
        chk("handshake", 64'(hs), 64'(1));
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk("drain_idle", 64'(busy), 64'(0));
    endtask

    task automatic wait_best(input int want);
        int n;
        n = 0;
        while (bestq.size() < want && n < 40) begin
            tick();
            n++;
        end
        chk("best_arrived", 64'(bestq.size() >= want), 64'(1));
    endtask

    initial begin
        int          lat;
        logic [31:0] hold_s;
        logic [11:0] hold_id;
        logic [31:0] exp_s [6];
        logic [31:0] stall_iou [6];

        vt[0] = '{W_ONES, mk(8'd10, 8'd4, 8'd20, 8'd25, 48'h123456_ABCDEF, 48'h123456_ABCDEF, 4'd2, 10'h200), 32'd15872};
        vt[1] = '{W_ONES, mk(8'd5, 8'd5, 8'd0, 8'd0, 48'h000000_0A141E, 48'hFF0001_000000, 4'd0, 10'd0), 32'd324608};
        vt[2] = '{W_ONES, mk(8'd0, 8'd255, 8'd0, 8'd0, 48'h0, 48'h0, 4'd15, 10'd1023), 32'd33816575};
        vt[3] = '{W_ONES, mk(8'd0, 8'd0, 8'd0, 8'd0, 48'h0, 48'h0, 4'd0, 10'd0), 32'd1024};
        vt[4] = '{48'h02_03_04_05_06_07, mk(8'd0, 8'd5, 8'd3, 8'd0, 48'h000000_0A141E, 48'hFF0001_000000, 4'd1, 10'd100), 32'd2037236};
        vt[5] = '{48'hFF_FF_FF_FF_FF_FF, mk(8'd0, 8'd255, 8'd255, 8'd0, 48'h0, 48'hFFFFFF_FFFFFF, 4'd15, 10'd1023), 32'hFFFFFFFF};

        reset_N = 1'b1; cfg_load = 1'b0; cfg_weights = '0; in_valid = 1'b0; in_last = 1'b0;
        in_id = '0; iou_dist = '0; w_cur = '0; w_prev = '0; h_cur = '0; h_prev = '0;
        color_cur = '0; color_prev = '0; d_history = '0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_score", 64'(out_score), 64'(0));
        chk("rst_best_valid", 64'(best_valid), 64'(0));
        chk("rst_best_count", 64'(best_count), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        reset_N = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            load_weights(vt[i].wts);
            cfg_weights = ~vt[i].wts;
            send(vt[i].f, 12'(100 + i), 1'b1);
            in_valid = 1'b0;
            wait_out(lat);
            chk("latency", 64'(lat), 64'(2));
            chk("vec_score", 64'(out_score), 64'(vt[i].exp));
            chk("vec_id", 64'(out_id), 64'(100 + i));
            chk("vec_last", 64'(out_last), 64'(1));
            tick();
            chk("vec_best_valid", 64'(best_valid), 64'(1));
            chk("vec_best_score", 64'(best_score), 64'(vt[i].exp));
            chk("vec_best_id", 64'(best_id), 64'(100 + i));
            chk("vec_best_count", 64'(best_count), 64'(1));
            tick();
            chk("vec_best_pulse_end", 64'(best_valid), 64'(0));
            chk("vec_idle", 64'(busy), 64'(0));
        end

        load_weights(W_ONES);
        send(vt[0].f, 12'd7, 1'b1);
        in_valid = 1'b0;
        cfg_load = 1'b1;
        cfg_weights = W_TWOS;
        tick();
        cfg_load = 1'b0;
        chk("cfg_err_busy_pulse", 64'(cfg_err), 64'(1));
        tick();
        chk("cfg_err_one_cycle", 64'(cfg_err), 64'(0));
        wait_out(lat);
        chk("old_weights_score", 64'(out_score), 64'(15872));
        wait_idle();
        load_weights(W_TWOS);
        send(vt[0].f, 12'd8, 1'b1);
        in_valid = 1'b0;
        wait_out(lat);
        chk("new_weights_score", 64'(out_score), 64'(31744));
        wait_idle();

        load_weights(W_IOU);
        outq.delete();
        bestq.delete();
        send(mk(0, 0, 0, 0, 0, 0, 0, 10'd300), 12'd1, 1'b0);
        send(mk(0, 0, 0, 0, 0, 0, 0, 10'd120), 12'd2, 1'b0);
        send(mk(0, 0, 0, 0, 0, 0, 0, 10'd120), 12'd3, 1'b0);
        send(mk(0, 0, 0, 0, 0, 0, 0, 10'd500), 12'd4, 1'b1);
        in_valid = 1'b0;
        wait_best(1);
        chk("grp_outs", 64'(outq.size()), 64'(4));
        chk("grp_best_score", 64'(bestq[0].s), 64'(120));
        chk("grp_best_id", 64'(bestq[0].id), 64'(2));
        chk("grp_best_count", 64'(bestq[0].cnt), 64'(4));
        wait_idle();

        stall_iou = '{32'd40, 32'd30, 32'd35, 32'd20, 32'd25, 32'd20};
        outq.delete();
        bestq.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(mk(0, 0, 0, 0, 0, 0, 0, 10'(stall_iou[i])), 12'(10 + i), (i == 2) || (i == 5));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                hold_s = out_score;
                hold_id = out_id;
                chk("stall_in_ready", 64'(in_ready), 64'(0));
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'(0));
                    chk("stall_out_valid", 64'(out_valid), 64'(1));
                    chk("stall_hold_score", 64'(out_score), 64'(hold_s));
                    chk("stall_hold_id", 64'(out_id), 64'(hold_id));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_best(2);
        chk("stall_out_count", 64'(outq.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            exp_s[i] = stall_iou[i];
            if (i < outq.size()) begin
                chk("stall_seq_id", 64'(outq[i].id), 64'(10 + i));
                chk("stall_seq_score", 64'(outq[i].s), 64'(exp_s[i]));
            end
        end
        chk("stall_groups", 64'(bestq.size()), 64'(2));
        if (bestq.size() >= 2) begin
            chk("grpA_score", 64'(bestq[0].s), 64'(30));
            chk("grpA_id", 64'(bestq[0].id), 64'(11));
            chk("grpA_count", 64'(bestq[0].cnt), 64'(3));
            chk("grpB_score", 64'(bestq[1].s), 64'(20));
            chk("grpB_id_tie", 64'(bestq[1].id), 64'(13));
            chk("grpB_count", 64'(bestq[1].cnt), 64'(3));
        end
        wait_idle();

        outq.delete();
        bestq.delete();
        send(mk(0, 0, 0, 0, 0, 0, 0, 10'd50), 12'd20, 1'b0);
        send(mk(0, 0, 0, 0, 0, 0, 0, 10'd60), 12'd21, 1'b0);
        in_valid = 1'b0;
        lat = 0;
        while (outq.size() < 2 && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        chk("accum_busy", 64'(busy), 64'(1));
        reset_N = 1'b1;
        tick();
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        tick();
        chk("mid_rst_best_valid", 64'(best_valid), 64'(0));
        reset_N = 1'b0;
        tick();
        load_weights(W_IOU);
        send(mk(0, 0, 0, 0, 0, 0, 0, 10'd77), 12'd30, 1'b1);
        in_valid = 1'b0;
        wait_best(1);
        repeat (3) tick();
        chk("post_rst_pulses", 64'(bestq.size()), 64'(1));
        if (bestq.size() >= 1) begin
            chk("post_rst_count", 64'(bestq[0].cnt), 64'(1));
            chk("post_rst_id", 64'(bestq[0].id), 64'(30));
            chk("post_rst_score", 64'(bestq[0].s), 64'(77));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
